// File: rtl/uart_param_core.sv
// Full-duplex UART on the oversample tick: TX frame starts the cycle after accept, tx_ready low for the whole frame.
// RX: 2-flop sync, mid-bit sampling, rx_valid pulses one cycle after the first stop sample; no RX back-pressure.
module uart_param_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 Div_CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 TX,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] BIT_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] BIT_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY != 0);
  localparam bit ODD     = (PARITY == 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  tx_state_t            tx_state;
  logic [TW-1:0]        tx_tmr;
  logic [3:0]           tx_cnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;

  always_ff @(posedge Div_CLK or posedge RST) begin
    if (RST) begin
      tx_state <= TX_IDLE;
      tx_tmr   <= '0;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      TX       <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_shift <= tx_data;
            tx_par   <= ODD ? ~^tx_data : ^tx_data;
            tx_tmr   <= '0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
            tx_ready <= 1'b0;
            TX       <= 1'b0;
          end
        end
        default: begin
          if (tx_tmr != BIT_LAST) begin
            tx_tmr <= tx_tmr + 1'b1;
          end else begin
            tx_tmr <= '0;
            // Bit boundary: TX is loaded with the next bit so it changes exactly on the boundary.
            case (tx_state)
              TX_START: begin
                tx_state <= TX_DATA;
                TX       <= tx_shift[0];
              end
              TX_DATA: begin
                if (tx_cnt == DATA_LAST) begin
                  tx_cnt <= '0;
                  if (HAS_PAR) begin
                    tx_state <= TX_PARITY;
                    TX       <= tx_par;
                  end else begin
                    tx_state <= TX_STOP;
                    TX       <= 1'b1;
                  end
                end else begin
                  tx_cnt   <= tx_cnt + 4'd1;
                  tx_shift <= tx_shift >> 1;
                  TX       <= tx_shift[1];
                end
              end
              TX_PARITY: begin
                tx_state <= TX_STOP;
                TX       <= 1'b1;
              end
              TX_STOP: begin
                if (tx_cnt == STOP_LAST) begin
                  tx_state <= TX_IDLE;
                  tx_ready <= 1'b1;
                end else begin
                  tx_cnt <= tx_cnt + 4'd1;
                end
              end
              default: tx_state <= TX_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  logic rx_meta;
  logic rxs;

  always_ff @(posedge Div_CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RX;
      rxs     <= rx_meta;
    end
  end

  rx_state_t            rx_state;
  logic [TW-1:0]        rx_tmr;
  logic [3:0]           rx_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bit;

  always_ff @(posedge Div_CLK or posedge RST) begin
    if (RST) begin
      rx_state      <= RX_IDLE;
      rx_tmr        <= '0;
      rx_cnt        <= '0;
      rx_shift      <= '0;
      rx_par_bit    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rxs) begin
            rx_state <= RX_START;
            rx_tmr   <= '0;
          end
        end
        RX_START: begin
          if (rx_tmr != BIT_MID) begin
            rx_tmr <= rx_tmr + 1'b1;
          end else begin
            // Re-zeroing here puts every later BIT_LAST sample at mid-bit.
            rx_tmr <= '0;
            rx_cnt <= '0;
            if (rxs) rx_state <= RX_IDLE;
            else     rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_tmr != BIT_LAST) begin
            rx_tmr <= rx_tmr + 1'b1;
          end else begin
            rx_tmr   <= '0;
            rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
            if (rx_cnt == DATA_LAST) begin
              if (HAS_PAR) rx_state <= RX_PARITY;
              else         rx_state <= RX_STOP;
            end else begin
              rx_cnt <= rx_cnt + 4'd1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_tmr != BIT_LAST) begin
            rx_tmr <= rx_tmr + 1'b1;
          end else begin
            rx_tmr     <= '0;
            rx_par_bit <= rxs;
            rx_state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_tmr != BIT_LAST) begin
            rx_tmr <= rx_tmr + 1'b1;
          end else begin
            rx_tmr        <= '0;
            rx_valid      <= 1'b1;
            rx_data       <= rx_shift;
            rx_parity_err <= HAS_PAR && (rx_par_bit != (ODD ? ~^rx_shift : ^rx_shift));
            rx_frame_err  <= !rxs;
            if (rxs) rx_state <= RX_IDLE;
            else     rx_state <= RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: begin
          if (rxs) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule
